// File: rtl/input_process_stage_if.sv
// Operand/result bundle between the upstream requester and input_process_stage.
// master = requester (drives start/operand), slave = the stage itself.
interface input_process_stage_if;
    logic        start;
    logic [31:0] FLOAT_x_input;
    logic [25:0] FIXED_frac_output;
    logic [7:0]  INT_n_output;
    logic        overflow_flag;
    logic        underflow_flag;
    logic        nan_flag;
    logic        busy;
    logic        output_ready;

    modport master (
        output start, FLOAT_x_input,
        input  FIXED_frac_output, INT_n_output, overflow_flag, underflow_flag,
               nan_flag, busy, output_ready
    );

    modport slave (
        input  start, FLOAT_x_input,
        output FIXED_frac_output, INT_n_output, overflow_flag, underflow_flag,
               nan_flag, busy, output_ready
    );
endinterface

// File: rtl/input_process_stage.sv
// Range reduction front end for exp(x): splits a float x into n = floor(x)
// (8-bit two's complement) and f = x - n (Q2.24), plus range/NaN flags.
// Fixed 5-cycle sequence IDLE -> DECODE -> ALIGN -> SPLIT -> DONE.
module input_process_stage (
    input  logic                  CLK,
    input  logic                  rst,
    input_process_stage_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, DECODE, ALIGN, SPLIT, DONE} state_t;

    state_t      r_state, w_next;
    logic        w_accept;

    logic [31:0] r_x;
    logic        r_s;
    logic [7:0]  r_e;
    logic [23:0] r_m;
    logic        r_mant_nz;

    logic [31:0] w_mag, r_mag;
    logic        r_big, r_nan;

    logic [31:0] w_val;
    logic [7:0]  w_n;
    logic        w_ov, w_un, w_any;

    logic [25:0] r_frac;
    logic [7:0]  r_n;
    logic        r_ov, r_un, r_nan_o, r_rdy;

    assign w_accept = (r_state == IDLE) && bus.start;

    // State register
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next state: only IDLE waits; start is ignored everywhere else
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = DECODE;
            DECODE:  w_next = ALIGN;
            ALIGN:   w_next = SPLIT;
            SPLIT:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Capture the operand on the accepting edge
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst)          r_x <= '0;
        else if (w_accept) r_x <= bus.FLOAT_x_input;
    end

    // DECODE: unpack sign, exponent and mantissa with hidden one (Q1.23)
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_s       <= 1'b0;
            r_e       <= '0;
            r_m       <= '0;
            r_mant_nz <= 1'b0;
        end else if (r_state == DECODE) begin
            r_s       <= r_x[31];
            r_e       <= r_x[30:23];
            r_m       <= {1'b1, r_x[22:0]};
            r_mant_nz <= |r_x[22:0];
        end
    end

    // ALIGN: magnitude in Q8.24 is M shifted by e-126. e < 103 (includes
    // zero/denormal) underflows to 0; e >= 134 is |x| >= 128 and left to flags.
    always_comb begin
        w_mag = '0;
        if (r_e < 8'd103 || r_e >= 8'd134)
            w_mag = '0;
        else if (r_e >= 8'd126)
            w_mag = {8'b0, r_m} << (r_e - 8'd126);
        else
            w_mag = {8'b0, r_m} >> (8'd126 - r_e);
    end

    // ALIGN register stage
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_mag <= '0;
            r_big <= 1'b0;
            r_nan <= 1'b0;
        end else if (r_state == ALIGN) begin
            r_mag <= w_mag;
            r_big <= (r_e >= 8'd134);
            r_nan <= (r_e == 8'hFF) && r_mant_nz;
        end
    end

    // SPLIT: signed value; two's complement truncation gives floor() for x < 0
    always_comb begin
        w_val = r_s ? (32'd0 - r_mag) : r_mag;
        w_n   = w_val[31:24];
        w_ov  = !r_nan && !r_s && (r_big || ($signed(w_n) >= 8'sd89));
        w_un  = !r_nan &&  r_s && (r_big || ($signed(w_n) <= -8'sd104));
        w_any = w_ov || w_un || r_nan;
    end

    // Result registers load on SPLIT -> DONE and hold until the next result
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_frac  <= '0;
            r_n     <= '0;
            r_ov    <= 1'b0;
            r_un    <= 1'b0;
            r_nan_o <= 1'b0;
        end else if (r_state == SPLIT) begin
            r_frac  <= w_any ? 26'd0 : {2'b00, w_val[23:0]};
            r_n     <= w_any ? 8'd0  : w_n;
            r_ov    <= w_ov;
            r_un    <= w_un;
            r_nan_o <= r_nan;
        end
    end

    // One-cycle ready pulse coinciding with DONE
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) r_rdy <= 1'b0;
        else      r_rdy <= (r_state == SPLIT);
    end

    assign bus.FIXED_frac_output = r_frac;
    assign bus.INT_n_output      = r_n;
    assign bus.overflow_flag     = r_ov;
    assign bus.underflow_flag    = r_un;
    assign bus.nan_flag          = r_nan_o;
    assign bus.output_ready      = r_rdy;
    assign bus.busy              = (r_state == DECODE) || (r_state == ALIGN) ||
                                   (r_state == SPLIT);
endmodule
